// File: rtl/ofmap_writeback.sv
// ofmap_writeback: requantizes signed accumulator vectors from the systolic
// array to int8 and serializes them, channel 0 first, into single-port writes
// at consecutive unified-buffer addresses.
//
// state | meaning
// IDLE  | waiting for ctrl_start; input ignored
// RUN   | accepting vectors until one carries in_last
// DRAIN | input closed; finish FIFO and serializer, then pulse flag_done
module ofmap_writeback #(
  parameter int dataSize      = 8,
  parameter int outputSize    = 24,
  parameter int numOutChannel = 3,
  parameter int numRegister   = 256,
  parameter int fifoDepth     = 4,
  localparam int AW           = $clog2(numRegister)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ctrl_start,
  input  logic [AW-1:0]                       cfg_start_addr,
  input  logic [4:0]                          cfg_shift,
  input  logic                                cfg_relu,
  input  logic                                in_valid,
  input  logic [numOutChannel*outputSize-1:0] in_data,
  input  logic                                in_last,
  output logic                                in_ready,
  output logic                                wr_en,
  output logic [AW-1:0]                       wr_addr,
  output logic [dataSize-1:0]                 wr_data,
  output logic                                flag_busy,
  output logic                                flag_done,
  output logic                                flag_overflow
);
  localparam int VW = numOutChannel * outputSize;
  localparam int PW = $clog2(fifoDepth);
  localparam int CW = $clog2(numOutChannel + 1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(fifoDepth);
  localparam logic [CW-1:0] NUM_CH   = CW'(numOutChannel);
  localparam logic [CW-1:0] LAST_REM = CW'(numOutChannel - 1);
  localparam logic [AW-1:0] TOP_ADDR = AW'(numRegister - 1);
  localparam logic signed [outputSize:0] SAT_MAX = (outputSize+1)'(2**(dataSize-1) - 1);
  localparam logic signed [outputSize:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [4:0]          shift_q, shift_d;
  logic                relu_q, relu_d;
  logic                in_ready_q, in_ready_d;
  logic                flag_done_q, flag_done_d;
  logic                flag_overflow_q, flag_overflow_d;
  logic [PW:0]         count_q, count_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [VW-1:0]       mem_q [fifoDepth];
  logic [VW-1:0]       mem_d [fifoDepth];
  logic [VW-1:0]       vec_q, vec_d;
  logic [CW-1:0]       rem_q, rem_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic                wr_en_q, wr_en_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [dataSize-1:0] wr_data_q, wr_data_d;

  logic                push, drop, pop, issue, fifo_empty, start_pass;
  logic [CW-1:0]       chan_sel;
  logic [VW-1:0]       src_vec;
  logic [outputSize-1:0] acc;
  int                  lo;

  // round half up, floor shift, optional ReLU, saturate to the output word
  function automatic logic [dataSize-1:0] requant(input logic [outputSize-1:0] x,
                                                  input logic [4:0] sh,
                                                  input logic relu);
    logic signed [outputSize:0] r;
    logic signed [outputSize:0] rnd;
    rnd = '0;
    if (sh != 5'd0) rnd[sh - 5'd1] = 1'b1;
    r = $signed({x[outputSize-1], x}) + rnd;
    r = r >>> sh;
    if (relu && r[outputSize]) r = '0;
    if (r > SAT_MAX) r = SAT_MAX;
    else if (r < SAT_MIN) r = SAT_MIN;
    return r[dataSize-1:0];
  endfunction

  assign start_pass = (state_q == IDLE) && ctrl_start;
  assign push       = (state_q == RUN) && in_valid && in_ready_q;
  assign drop       = (state_q == RUN) && in_valid && !in_ready_q;
  assign fifo_empty = (count_q == '0);
  assign pop        = (rem_q == '0) && !fifo_empty;
  assign issue      = pop || (rem_q != '0);

  // Pass sequencing, input handshake, overflow tracking and FIFO bookkeeping.
  always_comb begin
    state_d         = state_q;
    shift_d         = shift_q;
    relu_d          = relu_q;
    flag_done_d     = 1'b0;
    flag_overflow_d = flag_overflow_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    mem_d           = mem_q;
    count_d         = count_q;

    case (state_q)
      IDLE: begin
        if (ctrl_start) begin
          shift_d         = cfg_shift;
          relu_d          = cfg_relu;
          flag_overflow_d = 1'b0;
          state_d         = RUN;
        end
      end
      RUN: begin
        if (push && in_last) state_d = DRAIN;
        if (drop) flag_overflow_d = 1'b1;
      end
      DRAIN: begin
        if (fifo_empty && (rem_q == '0)) begin
          flag_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // registered ready: a full FIFO holds ready low even while it is popped
    in_ready_d = (state_d == RUN) && (count_d != FULL_CNT);
  end

  // Serializer: pops a vector when idle, then issues one channel per cycle
  // through the requantizer into the output register.
  always_comb begin
    rem_d     = rem_q;
    vec_d     = vec_q;
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    chan_sel  = '0;
    src_vec   = vec_q;
    lo        = 0;
    acc       = '0;

    if (pop) begin
      src_vec = mem_q[rd_ptr_q];
      vec_d   = mem_q[rd_ptr_q];
      rem_d   = LAST_REM;
    end else if (rem_q != '0) begin
      chan_sel = NUM_CH - rem_q;
      rem_d    = rem_q - 1'b1;
    end

    lo  = int'(chan_sel) * outputSize;
    acc = src_vec[lo +: outputSize];

    if (start_pass) begin
      ptr_d = cfg_start_addr;
    end else if (issue) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ptr_q;
      wr_data_d = requant(acc, shift_q, relu_q);
      ptr_d     = (ptr_q == TOP_ADDR) ? '0 : ptr_q + 1'b1;
    end
  end

  // Control and output registers; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      shift_q         <= '0;
      relu_q          <= 1'b0;
      in_ready_q      <= 1'b0;
      flag_done_q     <= 1'b0;
      flag_overflow_q <= 1'b0;
      count_q         <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      rem_q           <= '0;
      ptr_q           <= '0;
      wr_en_q         <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
    end else begin
      state_q         <= state_d;
      shift_q         <= shift_d;
      relu_q          <= relu_d;
      in_ready_q      <= in_ready_d;
      flag_done_q     <= flag_done_d;
      flag_overflow_q <= flag_overflow_d;
      count_q         <= count_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      rem_q           <= rem_d;
      ptr_q           <= ptr_d;
      wr_en_q         <= wr_en_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
    end
  end

  // Data storage; validity is tracked by count_q and rem_q, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    vec_q <= vec_d;
  end

  assign in_ready      = in_ready_q;
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign flag_busy     = (state_q != IDLE);
  assign flag_done     = flag_done_q;
  assign flag_overflow = flag_overflow_q;
endmodule

// File: tb/tb_ofmap_writeback.sv
// Directed bench for ofmap_writeback: table of single-vector passes plus
// hand-written sequences for address wrap, overflow, control edges and reset.
module tb_ofmap_writeback;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, ctrl_start, cfg_relu, in_valid, in_last;
  logic [AW-1:0] cfg_start_addr;
  logic [4:0]    cfg_shift;
  logic [71:0]   in_data;
  logic          in_ready, wr_en, flag_busy, flag_done, flag_overflow;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int wq_addr[$];
  int wq_data[$];
  int wq_cyc[$];

  typedef struct {
    int start; int shift; int relu;
    int x0; int x1; int x2;
    int e0; int e1; int e2;
  } vec_t;

  vec_t tbl [7];

  ofmap_writeback dut (
    .clk(clk), .rst(rst), .ctrl_start(ctrl_start),
    .cfg_start_addr(cfg_start_addr), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flag_busy(flag_busy), .flag_done(flag_done), .flag_overflow(flag_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(int'(wr_addr));
      wq_data.push_back($signed(wr_data));
      wq_cyc.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int k);
    if (k < q.size()) return q[k];
    return -999;
  endfunction

  function automatic logic [71:0] pack(input int a, input int b, input int c);
    return {24'(c), 24'(b), 24'(a)};
  endfunction

  task automatic wq_clear();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (flag_done) begin
        dc = cyc;
        break;
      end
    end
  endtask

  task automatic start_pass(input int start, input int shift, input int relu);
    next_cycle();
    ctrl_start     = 1'b1;
    cfg_start_addr = AW'(start);
    cfg_shift      = 5'(shift);
    cfg_relu       = 1'(relu);
    next_cycle();
    ctrl_start     = 1'b0;
  endtask

  // one vector with in_last; config inputs are scrambled after the latch
  task automatic single_pass(input string tag, input vec_t v);
    int n0, dc, ed;
    wq_clear();
    start_pass(v.start, v.shift, v.relu);
    cfg_start_addr = AW'(v.start + 77);
    cfg_shift      = 5'd0;
    cfg_relu       = ~1'(v.relu);
    check({tag, "_ready"}, int'(in_ready), 1);
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = pack(v.x0, v.x1, v.x2);
    n0 = cyc;
    next_cycle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_done(dc);
    check({tag, "_done_cyc"}, dc, n0 + 5);
    check({tag, "_busy_at_done"}, int'(flag_busy), 0);
    check({tag, "_nwrites"}, wq_addr.size(), 3);
    for (int k = 0; k < 3; k++) begin
      ed = (k == 0) ? v.e0 : (k == 1) ? v.e1 : v.e2;
      check($sformatf("%s_addr%0d", tag, k), qget(wq_addr, k), (v.start + k) % 256);
      check($sformatf("%s_data%0d", tag, k), qget(wq_data, k), ed);
      check($sformatf("%s_cyc%0d", tag, k), qget(wq_cyc, k), n0 + 2 + k);
    end
  endtask

  initial begin
    int n0, dc, saw_low, got;
    int acc_idx [8];
    vec_t post;

    tbl[0] = '{25,  4, 0, 291, -40, 16, 18, -2, 1};
    tbl[1] = '{100, 2, 0, -40, 5000, -5000, -10, 127, -128};
    tbl[2] = '{130, 2, 1, -40, 5000, -5000, 0, 127, 0};
    tbl[3] = '{7,   0, 0, 127, 128, -129, 127, 127, -128};
    tbl[4] = '{0,  23, 0, 8388607, -8388608, 0, 1, -1, 0};
    tbl[5] = '{253, 1, 1, -1, 1, 255, 0, 1, 127};
    tbl[6] = '{64,  3, 0, -3, -4, -5, 0, 0, -1};
    acc_idx = '{0, 1, 2, 3, 4, 5, 8, 10};

    rst = 1'b1; ctrl_start = 1'b0; cfg_start_addr = '0; cfg_shift = '0;
    cfg_relu = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(flag_busy), 0);
    check("rst_done", int'(flag_done), 0);
    check("rst_overflow", int'(flag_overflow), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    rst = 1'b0;

    // in_valid while IDLE is ignored
    wq_clear();
    in_valid = 1'b1; in_last = 1'b1; in_data = pack(5, 6, 7);
    repeat (6) next_cycle();
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) next_cycle();
    check("idle_nwrites", wq_addr.size(), 0);
    check("idle_overflow", int'(flag_overflow), 0);
    check("idle_busy", int'(flag_busy), 0);

    for (int i = 0; i < 7; i++) single_pass($sformatf("tbl%0d", i), tbl[i]);

    // address wrap with two back-to-back vectors
    wq_clear();
    start_pass(254, 0, 0);
    in_valid = 1'b1; in_last = 1'b0; in_data = pack(1, 2, 3);
    n0 = cyc;
    next_cycle();
    in_data = pack(4, 5, 6); in_last = 1'b1;
    next_cycle();
    in_valid = 1'b0; in_last = 1'b0;
    wait_done(dc);
    check("wrap_done_cyc", dc, n0 + 8);
    check("wrap_nwrites", wq_addr.size(), 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("wrap_addr%0d", k), qget(wq_addr, k), (254 + k) % 256);
      check($sformatf("wrap_data%0d", k), qget(wq_data, k), k + 1);
      check($sformatf("wrap_cyc%0d", k), qget(wq_cyc, k), n0 + 2 + k);
    end

    // overflow: 10 back-to-back vectors into a 4-deep FIFO
    wq_clear();
    start_pass(10, 0, 0);
    saw_low = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_last  = (i == 9);
      in_data  = pack(i, i + 16, i + 32);
      if (!in_ready) saw_low = 1;
      next_cycle();
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("ovf_ready_fell", saw_low, 1);
    check("ovf_flag_set", int'(flag_overflow), 1);
    got = 0;
    for (int t = 0; t < 20 && got == 0; t++) begin
      if (in_ready) begin
        in_valid = 1'b1; in_last = 1'b1; in_data = pack(10, 26, 42);
        got = 1;
      end
      next_cycle();
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("ovf_close_accepted", got, 1);
    wait_done(dc);
    check("ovf_done_seen", int'(dc >= 0), 1);
    check("ovf_flag_at_done", int'(flag_overflow), 1);
    check("ovf_nwrites", wq_addr.size(), 24);
    for (int j = 0; j < 24; j++) begin
      check($sformatf("ovf_data%0d", j), qget(wq_data, j), acc_idx[j / 3] + 16 * (j % 3));
      check($sformatf("ovf_addr%0d", j), qget(wq_addr, j), 10 + j);
    end
    repeat (3) next_cycle();
    check("ovf_flag_sticky", int'(flag_overflow), 1);

    // ctrl_start during RUN is ignored; new pass clears overflow
    wq_clear();
    start_pass(40, 1, 0);
    check("ctl_ovf_cleared", int'(flag_overflow), 0);
    check("ctl_busy", int'(flag_busy), 1);
    ctrl_start = 1'b1; cfg_start_addr = 8'd200; cfg_shift = 5'd0;
    next_cycle();
    ctrl_start = 1'b0;
    in_valid = 1'b1; in_last = 1'b1; in_data = pack(10, -10, 300);
    n0 = cyc;
    next_cycle();
    in_valid = 1'b0; in_last = 1'b0;
    wait_done(dc);
    check("ctl_done_cyc", dc, n0 + 5);
    check("ctl_nwrites", wq_addr.size(), 3);
    check("ctl_addr0", qget(wq_addr, 0), 40);
    check("ctl_addr2", qget(wq_addr, 2), 42);
    check("ctl_data0", qget(wq_data, 0), 5);
    check("ctl_data1", qget(wq_data, 1), -5);
    check("ctl_data2", qget(wq_data, 2), 127);

    // rst in the middle of serialization
    wq_clear();
    start_pass(60, 0, 0);
    in_valid = 1'b1; in_last = 1'b1; in_data = pack(7, 8, 9);
    next_cycle();
    in_valid = 1'b0; in_last = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check("rstmid_wr_en", int'(wr_en), 0);
    check("rstmid_busy", int'(flag_busy), 0);
    check("rstmid_ready", int'(in_ready), 0);
    repeat (5) next_cycle();
    check("rstmid_nwrites", wq_addr.size(), 2);
    check("rstmid_addr0", qget(wq_addr, 0), 60);
    check("rstmid_data1", qget(wq_data, 1), 8);
    check("rstmid_done", int'(flag_done), 0);
    post = '{70, 0, 0, 1, 2, 3, 1, 2, 3};
    single_pass("post_rst", post);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
